// File: rtl/stream_demux_1xn_if.sv
// Stream demux bus: one valid/ready input stream and N output streams.
// The slave modport is the demux. The master modport is the surrounding
// producer and consumers, which drive the input beat and the per-channel
// ready signals.
interface stream_demux_1xn_if #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 8,
    parameter int SEL_W  = 3
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [DATA_W-1:0]       in_data;
    logic                    in_last;
    logic [SEL_W-1:0]        in_sel;
    logic [N_OUT-1:0]        out_valid;
    logic [N_OUT-1:0]        out_ready;
    logic [N_OUT*DATA_W-1:0] out_data;
    logic [N_OUT-1:0]        out_last;

    modport master (
        output in_valid, in_data, in_last, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demultiplexer with one output register per channel.
// A beat is routed by in_sel, or by the first beat's in_sel for the whole
// packet when PKT_MODE=1. Beats aimed at a channel that does not exist are
// accepted, discarded, and flagged with a one-cycle drop pulse.
// Optional per-channel saturating beat counters: define STREAM_DEMUX_CNT_EN.
module stream_demux_1xn #(
    parameter int DATA_W   = 8,
    parameter int N_OUT    = 8,
    parameter int SEL_W    = 3,
    parameter int PKT_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_demux_1xn_if.slave     s,
    input  logic                  cnt_clr,
    output logic                  drop,
    output logic [N_OUT*16-1:0]   beat_cnt
);
    typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

    state_t                        state_q;
    logic [SEL_W-1:0]              cur_sel_q;
    logic [SEL_W-1:0]              tgt;
    logic                          tgt_in_range;
    logic                          tgt_busy;
    logic                          accept;
    logic [N_OUT-1:0]              wr_en;
    logic [N_OUT-1:0]              out_valid_q, out_valid_d;
    logic [N_OUT-1:0]              out_last_q, out_last_d;
    logic [N_OUT-1:0][DATA_W-1:0]  out_data_q, out_data_d;
    logic                          drop_q, drop_d;

    // Pick the route target and derive the input handshake from its register.
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        tgt          = (PKT_MODE != 0 && state_q == PKT) ? cur_sel_q : s.in_sel;
        tgt_in_range = (32'(tgt) < N_OUT);
        tgt_busy     = 1'b0;
        for (int k = 0; k < N_OUT; k++) begin
            if (32'(tgt) == k) tgt_busy = out_valid_q[k] && !s.out_ready[k];
        end
        // A target that does not exist is never busy, so that beat is always taken.
        s.in_ready = !tgt_busy;
        accept     = s.in_valid && !tgt_busy;
        for (int k = 0; k < N_OUT; k++) begin
            wr_en[k] = accept && (32'(tgt) == k);
        end
    end

    // Refill the written channel; let every other channel drain on its own ready.
    always_comb begin
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (wr_en[k]) begin
                out_valid_d[k] = 1'b1;
                out_data_d[k]  = s.in_data;
                out_last_d[k]  = s.in_last;
            end else if (s.out_ready[k]) begin
                out_valid_d[k] = 1'b0;
            end
        end
        drop_d = accept && !tgt_in_range;
    end

    // Output registers and the drop pulse.
    // NOTE: the data registers are reset as well, because the outputs must read zero during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= '0;
            out_last_q  <= '0;
            out_data_q  <= '0;
            drop_q      <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            drop_q      <= drop_d;
        end
    end

    // Track packet boundaries so follow-on beats reuse the first beat's target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cur_sel_q <= '0;
        end else if (PKT_MODE != 0 && accept) begin
            case (state_q)
                IDLE: if (!s.in_last) begin
                    cur_sel_q <= s.in_sel;
                    state_q   <= PKT;
                end
                PKT: if (s.in_last) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s.out_valid = out_valid_q;
    assign s.out_last  = out_last_q;
    assign s.out_data  = out_data_q;
    assign drop        = drop_q;

`ifdef STREAM_DEMUX_CNT_EN
    logic [N_OUT-1:0][15:0] cnt_q, cnt_d;

    // Count output handshakes per channel, saturating; clear has priority.
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (cnt_clr) begin
                cnt_d[k] = '0;
            end else if (out_valid_q[k] && s.out_ready[k] && cnt_q[k] != 16'hFFFF) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign beat_cnt = cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign beat_cnt       = '0;
`endif
endmodule

// File: tb/tb_stream_demux_1xn.sv
// Bench for stream_demux_1xn: dut0 uses the defaults (8 channels, per-beat
// routing); dut1 has 6 channels with packet-locked routing, so select values
// 6 and 7 are out of range. Output beats are checked against per-channel
// expected queues filled when the bench sees a beat accepted.
// Counter checks follow STREAM_DEMUX_CNT_EN.
module tb_stream_demux_1xn;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic cnt_clr0, cnt_clr1, drop0, drop1;
    logic [8*16-1:0] beat_cnt0;
    logic [6*16-1:0] beat_cnt1;

    stream_demux_1xn_if #(.DATA_W(8), .N_OUT(8), .SEL_W(3)) if0 ();
    stream_demux_1xn_if #(.DATA_W(8), .N_OUT(6), .SEL_W(3)) if1 ();

    stream_demux_1xn #(.DATA_W(8), .N_OUT(8), .SEL_W(3), .PKT_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s(if0), .cnt_clr(cnt_clr0), .drop(drop0), .beat_cnt(beat_cnt0)
    );
    stream_demux_1xn #(.DATA_W(8), .N_OUT(6), .SEL_W(3), .PKT_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s(if1), .cnt_clr(cnt_clr1), .drop(drop1), .beat_cnt(beat_cnt1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [8:0] sb0 [8][$];   // {last, data} per channel
    logic [8:0] sb1 [6][$];
    bit         m_in_pkt;     // packet-routing model for dut1
    logic [2:0] m_sel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output handshake against the front of its channel queue.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 8; k++) begin
                if (if0.out_valid[k] && if0.out_ready[k]) begin
                    if (sb0[k].size() == 0) check("d0_unexpected_beat_on_ch", 64'(k), 64'hFF);
                    else check("d0_beat", 64'({if0.out_last[k], if0.out_data[k*8 +: 8]}), 64'(sb0[k].pop_front()));
                end
            end
            for (int k = 0; k < 6; k++) begin
                if (if1.out_valid[k] && if1.out_ready[k]) begin
                    if (sb1[k].size() == 0) check("d1_unexpected_beat_on_ch", 64'(k), 64'hFF);
                    else check("d1_beat", 64'({if1.out_last[k], if1.out_data[k*8 +: 8]}), 64'(sb1[k].pop_front()));
                end
            end
        end
    end

    // Present one beat to dut0 and wait (bounded) until it is accepted.
    task automatic send0(input logic [2:0] sel, input logic [7:0] data, input logic last, input bit must_rdy);
        int budget;
        budget       = 0;
        if0.in_valid = 1'b1;
        if0.in_sel   = sel;
        if0.in_data  = data;
        if0.in_last  = last;
        @(negedge clk);
        if (must_rdy) check("d0_in_ready", 64'(if0.in_ready), 64'd1);
        while (!if0.in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!if0.in_ready) check("d0_accept_timeout_cycles", 64'(budget), 64'd0);
        else sb0[sel].push_back({last, data});
        @(posedge clk);
        #1;
    endtask

    // Present one beat to dut1 (all outputs ready) and check the drop flag.
    task automatic send1(input logic [2:0] sel, input logic [7:0] data, input logic last);
        logic [2:0] tgt;
        tgt          = m_in_pkt ? m_sel : sel;
        if1.in_valid = 1'b1;
        if1.in_sel   = sel;
        if1.in_data  = data;
        if1.in_last  = last;
        @(negedge clk);
        check("d1_in_ready", 64'(if1.in_ready), 64'd1);
        if (if1.in_ready) begin
            if (tgt < 3'd6) sb1[tgt].push_back({last, data});
            if (!m_in_pkt && !last) begin
                m_in_pkt = 1'b1;
                m_sel    = sel;
            end else if (m_in_pkt && last) begin
                m_in_pkt = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        if (tgt >= 3'd6) begin
            check("d1_drop_pulse", 64'(drop1), 64'd1);
            check("d1_no_output_on_drop", 64'(if1.out_valid), 64'd0);
        end else begin
            check("d1_no_drop", 64'(drop1), 64'd0);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        cnt_clr0 = 1'b0; cnt_clr1 = 1'b0;
        if0.in_valid = 1'b0; if0.in_sel = '0; if0.in_data = '0; if0.in_last = 1'b0; if0.out_ready = '1;
        if1.in_valid = 1'b0; if1.in_sel = '0; if1.in_data = '0; if1.in_last = 1'b0; if1.out_ready = '1;
        m_in_pkt = 1'b0; m_sel = '0;
        step(2);

        // Reset state
        check("rst_out_valid0", 64'(if0.out_valid), 64'd0);
        check("rst_out_data0",  64'(if0.out_data),  64'd0);
        check("rst_out_last0",  64'(if0.out_last),  64'd0);
        check("rst_drop0",      64'(drop0),         64'd0);
        check("rst_beat_cnt0",  64'(beat_cnt0[63:0]), 64'd0);
        check("rst_out_valid1", 64'(if1.out_valid), 64'd0);
        check("rst_drop1",      64'(drop1),         64'd0);
        rst_n = 1'b1;
        step(1);
        check("idle_in_ready0", 64'(if0.in_ready), 64'd1);

        // Back-to-back beats to every channel, one-cycle latency
        for (int k = 0; k < 8; k++) begin
            send0(3'(k), 8'(8'hA0 + k), 1'b0, 1'b1);
            check("d0_sweep_onehot_valid", 64'(if0.out_valid), 64'(8'd1 << k));
        end
        if0.in_valid = 1'b0;
        step(1);
        check("d0_sweep_drained", 64'(if0.out_valid), 64'd0);

        // Stalled channel 3 blocks only beats aimed at it
        if0.out_ready = 8'hF7;
        send0(3'd3, 8'h11, 1'b0, 1'b1);
        check("d0_stall_first_held", 64'(if0.out_valid), 64'h08);
        send0(3'd5, 8'h55, 1'b0, 1'b1);
        check("d0_other_channel_passes", 64'(if0.out_valid), 64'h28);
        if0.in_valid = 1'b1; if0.in_sel = 3'd3; if0.in_data = 8'h22; if0.in_last = 1'b1;
        @(negedge clk);
        check("d0_stall_in_ready_low", 64'(if0.in_ready), 64'd0);
        check("d0_stall_data_held", 64'(if0.out_data[31:24]), 64'h11);
        @(negedge clk);
        check("d0_stall_in_ready_low2", 64'(if0.in_ready), 64'd0);
        check("d0_stall_data_held2", 64'(if0.out_data[31:24]), 64'h11);
        @(posedge clk);
        #1;
        if0.out_ready = 8'hFF;
        #1;
        check("d0_passthrough_in_ready", 64'(if0.in_ready), 64'd1);
        sb0[3].push_back({1'b1, 8'h22});
        @(posedge clk);
        #1;
        if0.in_valid = 1'b0;
        check("d0_refill_valid", 64'(if0.out_valid), 64'h08);
        check("d0_refill_data", 64'(if0.out_data[31:24]), 64'h22);
        check("d0_refill_last", 64'(if0.out_last[3]), 64'd1);
        step(2);
        check("d0_stall_drained", 64'(if0.out_valid), 64'd0);

        // Out-of-range targets on the 6-channel instance
        send1(3'd7, 8'h77, 1'b1);
        if1.in_valid = 1'b0;
        step(1);
        check("d1_drop_one_cycle", 64'(drop1), 64'd0);
        send1(3'd6, 8'h66, 1'b1);
        if1.in_valid = 1'b0;
        step(1);
        check("d1_drop_boundary_clear", 64'(drop1), 64'd0);

        // Packet-locked routing: in_sel ignored after the first beat
        send1(3'd2, 8'hC0, 1'b0);
        send1(3'd0, 8'hC1, 1'b0);
        send1(3'd5, 8'hC2, 1'b0);
        send1(3'd0, 8'hC3, 1'b1);
        check("d1_pkt_last_on_ch2", 64'({if1.out_valid[2], if1.out_last[2]}), 64'd3);
        send1(3'd4, 8'hC4, 1'b1);
        check("d1_next_pkt_ch4", 64'(if1.out_valid), 64'h10);
        if1.in_valid = 1'b0;
        step(2);

        // Whole packet dropped when its first beat is out of range
        send1(3'd7, 8'hD0, 1'b0);
        send1(3'd1, 8'hD1, 1'b0);
        send1(3'd1, 8'hD2, 1'b1);
        send1(3'd1, 8'hD3, 1'b1);
        check("d1_after_dropped_pkt_ch1", 64'(if1.out_valid), 64'h02);
        if1.in_valid = 1'b0;
        step(2);

        // Reset mid-packet: held beat lost, next beat is a first beat
        send1(3'd3, 8'hE0, 1'b0);
        send1(3'd3, 8'hE1, 1'b0);
        if1.out_ready = 6'b110111;
        if1.in_valid  = 1'b0;
        @(negedge clk);
        check("d1_held_before_reset", 64'({if1.out_valid[3], if1.out_data[31:24]}), 64'h1E1);
        rst_n = 1'b0;
        #1;
        check("d1_async_reset_valid", 64'(if1.out_valid), 64'd0);
        check("d1_async_reset_data", 64'(if1.out_data), 64'd0);
        check("d1_async_reset_last", 64'(if1.out_last), 64'd0);
        for (int k = 0; k < 8; k++) sb0[k].delete();
        for (int k = 0; k < 6; k++) sb1[k].delete();
        m_in_pkt = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        if1.out_ready = '1;
        step(1);
        send1(3'd1, 8'hE2, 1'b1);
        check("d1_post_reset_ch1", 64'(if1.out_valid), 64'h02);
        if1.in_valid = 1'b0;
        step(2);

`ifdef STREAM_DEMUX_CNT_EN
        // Saturating counters with clear priority
        check("cnt_d1_ch1", 64'(beat_cnt1[31:16]), 64'd1);
        for (int i = 0; i < 5; i++) send0(3'd0, 8'(i), 1'b0, 1'b1);
        if0.in_valid = 1'b0;
        step(2);
        check("cnt_five_beats", 64'(beat_cnt0[15:0]), 64'd5);
        send0(3'd0, 8'hF5, 1'b0, 1'b1);
        cnt_clr0 = 1'b1;
        if0.in_valid = 1'b0;
        step(1);
        cnt_clr0 = 1'b0;
        check("cnt_clr_beats_increment", 64'(beat_cnt0[15:0]), 64'd0);
        for (int i = 0; i < 65540; i++) send0(3'd0, 8'(i), 1'b0, 1'b0);
        if0.in_valid = 1'b0;
        step(2);
        check("cnt_saturated", 64'(beat_cnt0[15:0]), 64'hFFFF);
        check("cnt_other_ch_zero", 64'(beat_cnt0[31:16]), 64'd0);
`else
        // Counters absent: outputs tied low and clear has no effect
        cnt_clr0 = 1'b1;
        step(1);
        cnt_clr0 = 1'b0;
        check("cnt_absent0", 64'(beat_cnt0[63:0]), 64'd0);
        check("cnt_absent0_hi", 64'(beat_cnt0[127:64]), 64'd0);
        check("cnt_absent1", 64'(beat_cnt1[63:0]), 64'd0);
`endif

        // Every expected beat was delivered
        for (int k = 0; k < 8; k++) check("d0_sb_empty", 64'(sb0[k].size()), 64'd0);
        for (int k = 0; k < 6; k++) check("d1_sb_empty", 64'(sb1[k].size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
